// File: rtl/noc_output_arbiter_if.sv
// Handshake bundle between the competing input ports, the arbiter and the downstream output port.
// master = traffic side (sources and downstream sink), slave = arbiter side.
interface noc_output_arbiter_if #(
  parameter int NUM_INPUTS = 5,
  parameter int FLIT_WIDTH = 34
);
  logic [NUM_INPUTS-1:0]                 in_valid;
  logic [NUM_INPUTS-1:0][FLIT_WIDTH-1:0] in_flit;
  logic [NUM_INPUTS-1:0]                 in_ready;
  logic                                  out_valid;
  logic [FLIT_WIDTH-1:0]                 out_flit;
  logic                                  out_ready;

  modport master (
    output in_valid, in_flit, out_ready,
    input  in_ready, out_valid, out_flit
  );

  modport slave (
    input  in_valid, in_flit, out_ready,
    output in_ready, out_valid, out_flit
  );
endinterface

// File: rtl/noc_output_arbiter.sv
// Round-robin, packet-locked arbiter for one router output port; flit type lives in the top 2 bits.
// Optional lock watchdog enabled by defining NOC_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no owner; HEADER requesters arbitrated, winner registered
// LOCKED | owner forwarded combinationally until its TAIL transfers (or watchdog fires)
module noc_output_arbiter #(
  parameter int NUM_INPUTS     = 5,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int FLIT_WIDTH     = 34
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_output_arbiter_if.slave   bus,
  output logic [NUM_INPUTS-1:0] grant,
  output logic                  locked,
  output logic                  timeout_err
);

  localparam int PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [1:0] TYPE_HEADER = 2'd0;
  localparam logic [1:0] TYPE_TAIL   = 2'd2;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     winner, scan_idx;
  logic [NUM_INPUTS-1:0] cand;
  logic                 found;
  logic [1:0]           owner_type;
  logic                 out_xfer;
  logic                 wd_expire;

  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cand[i] = bus.in_valid[i] && (bus.in_flit[i][FLIT_WIDTH-1 -: 2] == TYPE_HEADER);
    end
  end

  // Scan upward starting one past the last owner so every requester gets a turn.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_INPUTS);
      if (!found && cand[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= PTR_W'(NUM_INPUTS - 1);
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    bus.in_ready  = '0;
    bus.out_valid = 1'b0;
    bus.out_flit  = '0;
    grant         = '0;
    locked        = 1'b0;
    out_xfer      = 1'b0;
    owner_type    = bus.in_flit[owner_q][FLIT_WIDTH-1 -: 2];
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = winner;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        bus.out_valid         = bus.in_valid[owner_q];
        bus.out_flit          = bus.in_flit[owner_q];
        bus.in_ready[owner_q] = bus.out_ready;
        grant[owner_q]        = 1'b1;
        locked                = 1'b1;
        out_xfer              = bus.in_valid[owner_q] && bus.out_ready;
        if ((out_xfer && owner_type == TYPE_TAIL) || wd_expire) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef NOC_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            timeout_err_q;

  // Counts stalled LOCKED cycles; held at zero outside LOCKED so entry starts fresh.
  assign wd_expire = (state_q == LOCKED) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= wd_expire;
      if (state_q != LOCKED || out_xfer) begin
        wd_cnt_q <= '0;
      end else if (!wd_expire) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Scoreboard bench for noc_output_arbiter: per-input flit sources, expected output order queued at load time.
module tb_noc_output_arbiter;
  localparam int NI = 5;
  localparam int FW = 16;
  localparam int TO = 8;
  localparam logic [1:0] T_HDR  = 2'd0;
  localparam logic [1:0] T_DAT  = 2'd1;
  localparam logic [1:0] T_TAIL = 2'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] grant;
  logic          locked;
  logic          timeout_err;

  noc_output_arbiter_if #(.NUM_INPUTS(NI), .FLIT_WIDTH(FW)) bus ();

  noc_output_arbiter #(
    .NUM_INPUTS(NI), .TIMEOUT_CYCLES(TO), .FLIT_WIDTH(FW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .grant(grant), .locked(locked), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [FW-1:0] src_q [NI][$];
  logic [FW-1:0] exp_q [$];
  int            hdr_cyc [$];
  logic [NI-1:0] en;
  logic [NI-1:0] in_xfer;
  logic [NI-1:0] s_grant;
  logic          s_locked, s_tout, s_oval, s_oxfer;
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            n_bad;
  int            n_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int src, input int seq);
    return {t, 6'(src), 8'(seq)};
  endfunction

  task automatic load_pkt(input int src, input int n, input bit expect_out);
    logic [FW-1:0] f;
    for (int s = 0; s < n; s++) begin
      f = mk((s == 0) ? T_HDR : ((s == n - 1) ? T_TAIL : T_DAT), src, s);
      src_q[src].push_back(f);
      if (expect_out) exp_q.push_back(f);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      bus.in_valid[i] = en[i] && (src_q[i].size() > 0);
      bus.in_flit[i]  = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  task automatic sample();
    logic [FW-1:0] e;
    in_xfer  = bus.in_valid & bus.in_ready;
    s_oxfer  = bus.out_valid && bus.out_ready;
    s_oval   = bus.out_valid;
    s_grant  = grant;
    s_locked = locked;
    s_tout   = timeout_err;
    chk("ready_outside_grant", 32'(bus.in_ready & ~grant), 32'd0);
    chk("locked_vs_grant", 32'(locked), 32'(|grant));
    if (s_oxfer) begin
      if (exp_q.size() == 0) begin
        chk("sb_spurious_flit", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("out_flit", 32'(bus.out_flit), 32'(e));
        chk("owner_src", 32'(grant), 32'(NI'(1) << e[13:8]));
        chk("src_pop", 32'(in_xfer), 32'(grant));
        if (e[FW-1 -: 2] == T_HDR) hdr_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NI; i++)
      if (in_xfer[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) src_q[i].delete();
    exp_q.delete();
    hdr_cyc.delete();
    en = '1;
    tick();
    tick();
    chk("rst_grant", 32'(s_grant), 32'd0);
    chk("rst_locked", 32'(s_locked), 32'd0);
    chk("rst_out_valid", 32'(s_oval), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_timeout", 32'(s_tout), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    en            = '1;
    in_xfer       = '0;
    bus.in_valid  = '0;
    bus.in_flit   = '0;
    bus.out_ready = 1'b1;

    // Single 3-flit packet on input 2
    apply_reset();
    load_pkt(2, 3, 1'b1);
    tick();
    chk("t1_arb_latency", 32'(s_grant), 32'd0);
    tick();
    chk("t1_grant", 32'(s_grant), 32'b00100);
    chk("t1_xfer_hdr", 32'(s_oxfer), 32'd1);
    tick();
    chk("t1_xfer_dat", 32'(s_oxfer), 32'd1);
    tick();
    chk("t1_xfer_tail", 32'(s_oxfer), 32'd1);
    chk("t1_locked_at_tail", 32'(s_locked), 32'd1);
    tick();
    chk("t1_unlocked", 32'(s_locked), 32'd0);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Three simultaneous requesters served 0,1,3 with one bubble each
    apply_reset();
    load_pkt(0, 2, 1'b1);
    load_pkt(1, 2, 1'b1);
    load_pkt(3, 2, 1'b1);
    run_drain(30);
    chk("t2_headers", 32'(hdr_cyc.size()), 32'd3);
    if (hdr_cyc.size() == 3) begin
      chk("t2_gap_0_1", 32'(hdr_cyc[1] - hdr_cyc[0]), 32'd3);
      chk("t2_gap_1_3", 32'(hdr_cyc[2] - hdr_cyc[1]), 32'd3);
    end

    // Input 4 requests while input 1 owns the port
    hdr_cyc.delete();
    load_pkt(1, 4, 1'b1);
    tick();
    tick();
    chk("t3_owner1", 32'(s_grant), 32'b00010);
    load_pkt(4, 2, 1'b1);
    tick();
    chk("t3_no_ready4", 32'(bus.in_ready[4]), 32'd0);
    run_drain(40);
    chk("t3_headers", 32'(hdr_cyc.size()), 32'd2);
    if (hdr_cyc.size() == 2)
      chk("t3_gap", 32'(hdr_cyc[1] - hdr_cyc[0]), 32'd5);

    // DATA presented in IDLE never wins
    src_q[3].push_back(mk(T_DAT, 3, 0));
    n_bad = 0;
    repeat (10) begin
      tick();
      if (s_grant != '0 || s_oval) n_bad++;
    end
    chk("t4_data_never_wins", 32'(n_bad), 32'd0);
    src_q[3].delete();
    tick();
    tick();

    // Downstream stall holds ownership, no loss or duplication
    load_pkt(0, 4, 1'b1);
    tick();
    tick();
    bus.out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("t5_hold_grant", 32'(s_grant), 32'b00001);
      chk("t5_no_xfer", 32'(s_oxfer), 32'd0);
    end
    bus.out_ready = 1'b1;
    run_drain(20);

    // Reset mid-packet
    load_pkt(2, 4, 1'b1);
    tick();
    tick();
    tick();
    chk("t5b_mid_locked", 32'(s_locked), 32'd1);
    rst = 1'b1;
    tick();
    chk("t5b_rst_locked", 32'(s_locked), 32'd0);
    chk("t5b_rst_grant", 32'(s_grant), 32'd0);
    rst = 1'b0;
    src_q[2].delete();
    exp_q.delete();
    tick();

    // Owner stalls after HEADER; input 4 waits
    apply_reset();
    src_q[1].push_back(mk(T_HDR, 1, 0));
    exp_q.push_back(mk(T_HDR, 1, 0));
    tick();
    tick();
    chk("t6_owner1", 32'(s_grant), 32'b00010);
`ifdef NOC_ARB_TIMEOUT_EN
    load_pkt(4, 2, 1'b1);
    n_to = 0;
    repeat (30) begin
      tick();
      if (s_tout) n_to++;
    end
    chk("t6_timeout_pulses", 32'(n_to), 32'd1);
    chk("t6_next_owner_served", 32'(exp_q.size()), 32'd0);
`else
    load_pkt(4, 2, 1'b0);
    n_bad = 0;
    n_to  = 0;
    repeat (110) begin
      tick();
      if (!s_locked || s_grant != 5'b00010) n_bad++;
      if (s_tout) n_to++;
    end
    chk("t6_lock_held", 32'(n_bad), 32'd0);
    chk("t6_no_timeout", 32'(n_to), 32'd0);
`endif
    apply_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/noc_output_arbiter.md
NOC_OUTPUT_ARBITER -- requirements
Module: noc_output_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 5, giving the number of input ports competing for one router output port.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the stall limit used only when NOC_ARB_TIMEOUT_EN is defined.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  NUM_INPUTS  per-input flit valid.
REQ-006 The block SHALL have port in_flit  input  NUM_INPUTS x FLIT_WIDTH  per-input flit (noc_types::flit_t: 2-bit type HEADER=0/DATA=1/TAIL=2, then payload).
REQ-007 The block SHALL have port in_ready  output  NUM_INPUTS  per-input flit accepted.
REQ-008 The block SHALL have port out_valid  output  1  output flit valid.
REQ-009 The block SHALL have port out_flit  output  FLIT_WIDTH  output flit.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts flit.
REQ-011 The block SHALL have port grant  output  NUM_INPUTS  one-hot current owner, all-zero when unowned.
REQ-012 The block SHALL have port locked  output  1  output port owned by a packet.
REQ-013 The block SHALL have port timeout_err  output  1  one-cycle pulse on watchdog release.

Function
REQ-014 A transfer SHALL occur on input i only when in_valid[i] and in_ready[i] are both high in the same cycle; likewise out_valid and out_ready on the output.
REQ-015 The FSM SHALL have exactly two states: IDLE and LOCKED.
REQ-016 In IDLE: in_ready all 0, out_valid 0, grant 0, locked 0.
REQ-017 In IDLE, inputs with in_valid high and flit type HEADER SHALL be candidates; inputs presenting DATA, TAIL or reserved type SHALL never win.
REQ-018 Winner selection SHALL be round-robin: first candidate scanning upward from (rr_ptr+1) mod NUM_INPUTS; the winner is registered and the FSM enters LOCKED next cycle (one-cycle arbitration latency).
REQ-019 In LOCKED with owner g: out_valid = in_valid[g], out_flit = in_flit[g], in_ready[g] = out_ready, all other in_ready 0, grant = one-hot(g), locked 1; zero-latency combinational forwarding.
REQ-020 In LOCKED, a transfer of a TAIL flit SHALL return the FSM to IDLE next cycle and set rr_ptr = g.
REQ-021 In LOCKED, HEADER, DATA and reserved-type flits SHALL be forwarded unchanged without state change.
REQ-022 Each packet SHALL therefore cost one idle bubble cycle between TAIL transfer and the next HEADER transfer; a new request present at TAIL time is arbitrated in the following IDLE cycle.
REQ-023 The out_ready input SHALL never influence arbitration; a stalled owner holds the lock indefinitely (absent REQ-027).
REQ-024 rr_ptr SHALL be ceil(log2(NUM_INPUTS)) bits (min 1) and wrap from NUM_INPUTS-1 to 0.

Reset
REQ-025 On rst high at a clock edge: state IDLE, rr_ptr = NUM_INPUTS-1 (input 0 highest priority first), owner 0, watchdog counter 0, timeout_err 0; all outputs take REQ-016 values in the following cycle, including when asserted mid-packet.

Configuration
REQ-026 Macro NOC_ARB_TIMEOUT_EN SHALL select the lock watchdog; when undefined, no counter is built and timeout_err is tied 0.
REQ-027 When defined: counter clears on entering LOCKED and on each output transfer, increments each LOCKED cycle without transfer; upon reaching TIMEOUT_CYCLES the FSM returns to IDLE next cycle, rr_ptr = g, and timeout_err pulses high for exactly that one cycle.

Verification
REQ-028 Reset, then input 2 HEADER,DATA,TAIL with out_ready=1 -> grant=00100 one cycle after HEADER valid; three consecutive out transfers; locked falls the cycle after TAIL.
REQ-029 Inputs 0,1,3 all present 2-flit packets simultaneously after reset -> served in order 0,1,3, each separated by one bubble cycle.
REQ-030 Input 1 owns, input 4 raises HEADER mid-packet -> in_ready[4] stays 0 until input 1 TAIL transfers; input 4 granted in following IDLE cycle.
REQ-031 Input 3 presents DATA in IDLE with no other requester -> never granted, out_valid stays 0.
REQ-032 Owner holds out_ready=0 for 3 cycles then 1 -> no grant change, flits delivered in order, none duplicated or lost; rst asserted mid-packet -> locked=0, grant=0 next cycle.
REQ-033 With NOC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, owner stops after HEADER -> timeout_err one-cycle pulse, lock released, next waiting input granted; without macro, lock held for 100+ cycles, timeout_err stays 0.
